// File: rtl/avg_window_engine.sv
// Windowed averager fed from a FIFO read port: block or sliding windows of 2^LOG2_N
// samples, optional round-half-up, ready/valid output with a one-entry skid.
module avg_window_engine #(
    parameter int WIDTH  = 8,
    parameter int LOG2_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             rEmpty,
    output logic             rd_En,
    input  logic             mode,
    input  logic             round_en,
    input  logic             clr,
    output logic [WIDTH-1:0] average,
    output logic             avg_valid,
    input  logic             avg_ready
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = WIDTH + LOG2_N;
    localparam logic [LOG2_N:0]  FILL_FULL = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [SUM_W-1:0] ROUND_ADD = {{(SUM_W-1){1'b0}}, 1'b1} << (LOG2_N - 1);

    logic              rd_en_q, rd_en_d;
    logic              skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0]  skid_q, skid_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [LOG2_N:0]   fill_q, fill_d;
    logic [LOG2_N-1:0] wp_q, wp_d;
    logic [WIDTH-1:0]  ring_q [N];
    logic [WIDTH-1:0]  ring_d [N];
    logic [WIDTH-1:0]  average_q, average_d;
    logic              avg_valid_q, avg_valid_d;
    logic              mode_q, mode_d;
    logic              round_en_q, round_en_d;

    logic              stall;
    logic              proc_valid;
    logic [WIDTH-1:0]  proc_sample;
    logic [SUM_W-1:0]  sample_ext, oldest_ext, new_sum, rounded;
    logic [LOG2_N:0]   fill_next;
    logic              hit;
    logic [WIDTH-1:0]  res;

    // Only one read can be outstanding, so an empty skid always has room for it.
    always_comb begin
        stall        = avg_valid_q & ~avg_ready;
        rd_En        = ~reset & ~rEmpty & ~skid_valid_q & ~stall;
        rd_en_d      = rd_En;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (stall && rd_en_q) begin
            skid_valid_d = 1'b1;
            skid_d       = data;
        end else if (!stall && skid_valid_q) begin
            skid_valid_d = 1'b0;
        end
        proc_valid  = ~stall & (skid_valid_q | rd_en_q);
        proc_sample = skid_valid_q ? skid_q : data;
    end

    always_comb begin
        sample_ext = {{LOG2_N{1'b0}}, proc_sample};
        oldest_ext = {{LOG2_N{1'b0}}, ring_q[wp_q]};
        new_sum    = '0;
        fill_next  = '0;
        hit        = 1'b0;
        if (mode_q) begin
            new_sum   = sum_q + sample_ext - oldest_ext;
            fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
            hit       = (fill_next == FILL_FULL);
        end else begin
            new_sum   = (fill_q == '0) ? sample_ext : sum_q + sample_ext;
            fill_next = fill_q + 1'b1;
            if (fill_next == FILL_FULL) begin
                hit       = 1'b1;
                fill_next = '0;
            end
        end
        rounded = new_sum + (round_en_q ? ROUND_ADD : '0);
        res     = rounded[SUM_W-1:LOG2_N];
    end

    // A sample processed in a clr cycle is consumed but contributes nothing.
    always_comb begin
        sum_d       = sum_q;
        fill_d      = fill_q;
        wp_d        = wp_q;
        ring_d      = ring_q;
        mode_d      = mode_q;
        round_en_d  = round_en_q;
        average_d   = average_q;
        avg_valid_d = avg_valid_q;
        if (clr) begin
            sum_d      = '0;
            fill_d     = '0;
            wp_d       = '0;
            ring_d     = '{default: '0};
            mode_d     = mode;
            round_en_d = round_en;
        end else if (proc_valid) begin
            sum_d  = new_sum;
            fill_d = fill_next;
            if (mode_q) begin
                ring_d[wp_q] = proc_sample;
                wp_d         = wp_q + 1'b1;
            end
        end
        if (!clr && proc_valid && hit) begin
            average_d   = res;
            avg_valid_d = 1'b1;
        end else if (avg_valid_q && avg_ready) begin
            avg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            wp_q         <= '0;
            ring_q       <= '{default: '0};
            average_q    <= '0;
            avg_valid_q  <= 1'b0;
            mode_q       <= mode;
            round_en_q   <= round_en;
        end else begin
            rd_en_q      <= rd_en_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            sum_q        <= sum_d;
            fill_q       <= fill_d;
            wp_q         <= wp_d;
            ring_q       <= ring_d;
            average_q    <= average_d;
            avg_valid_q  <= avg_valid_d;
            mode_q       <= mode_d;
            round_en_q   <= round_en_d;
        end
    end

    assign average   = average_q;
    assign avg_valid = avg_valid_q;

endmodule
